// File: rtl/final_fifo_link_receiver.sv
// final_fifo_link_receiver
// Receive end of the inter-half link. Narrow link beats are reassembled into
// final-FIFO words, buffered in a small FIFO and presented on a valid/ready
// interface to the local final arbitration unit. Header beats also carry the
// remote half's status flags, which are decoded for the local stage controller.
//
// Header beat layout: [1:0] type, [2] has_message_flying, [3] has_odd_clusters.
//   type 2'b01 : data header, followed by BEATS payload beats (LSB first)
//   type 2'b10 : status-only frame
//   type 2'b00 / 2'b11 : illegal, beat dropped, protocol_error set

module final_fifo_link_receiver #(
    parameter int CODE_DISTANCE_X = 5,
    parameter int CODE_DISTANCE_Z = 4,
    parameter int LINK_WIDTH      = 8,   // must be >= 4 to carry the header fields
    parameter int FIFO_DEPTH      = 4    // power of two, >= 2
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [LINK_WIDTH-1:0]                 link_in_data,
    input  logic                                  link_in_valid,
    output logic                                  link_in_ready,
    output logic [(2*(3*$clog2((CODE_DISTANCE_X > CODE_DISTANCE_Z) ? CODE_DISTANCE_X : CODE_DISTANCE_Z))+2)
                  + $clog2(((CODE_DISTANCE_X > CODE_DISTANCE_Z) ? CODE_DISTANCE_X : CODE_DISTANCE_Z)
                           * CODE_DISTANCE_Z) - 1:0] final_fifo_in_data,
    output logic                                  final_fifo_in_valid,
    input  logic                                  final_fifo_in_ready,
    output logic                                  has_message_flying_otherside,
    output logic                                  has_odd_clusters_otherside,
    output logic                                  status_seen,
    output logic                                  protocol_error,
    output logic [$clog2(FIFO_DEPTH):0]           fifo_count
);

    // ------------------------------------------------------------------
    // Derived widths
    // ------------------------------------------------------------------
    localparam int MEASUREMENT_ROUNDS = (CODE_DISTANCE_X > CODE_DISTANCE_Z) ? CODE_DISTANCE_X
                                                                             : CODE_DISTANCE_Z;
    localparam int ADDRESS_WIDTH      = 3 * $clog2(MEASUREMENT_ROUNDS);
    localparam int MASTER_FIFO_WIDTH  = 2 * ADDRESS_WIDTH + 2;
    localparam int FIFO_COUNT         = MEASUREMENT_ROUNDS * CODE_DISTANCE_Z;
    localparam int FINAL_FIFO_WIDTH   = MASTER_FIFO_WIDTH + $clog2(FIFO_COUNT);
    localparam int BEATS              = (FINAL_FIFO_WIDTH + LINK_WIDTH - 1) / LINK_WIDTH;
    localparam int BEAT_W             = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int ASM_W              = BEATS * LINK_WIDTH;
    localparam int PTR_W              = $clog2(FIFO_DEPTH);
    localparam int CNT_W              = PTR_W + 1;

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(FIFO_DEPTH);

    // FSM encoding
    localparam logic [0:0] ST_HDR     = 1'b0;
    localparam logic [0:0] ST_PAYLOAD = 1'b1;

    // Header type encoding
    localparam logic [1:0] HDR_DATA   = 2'b01;
    localparam logic [1:0] HDR_STATUS = 2'b10;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [0:0]                  state_q;
    logic [BEAT_W-1:0]           beat_cnt_q;
    logic [ASM_W-1:0]            asm_q;
    logic [ASM_W-1:0]            asm_next;

    logic [FINAL_FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]            wr_ptr_q;
    logic [PTR_W-1:0]            rd_ptr_q;
    logic [CNT_W-1:0]            count_q;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic       fifo_full;
    logic       fifo_empty;
    logic       last_beat;
    logic       beat_fire;
    logic       hdr_fire;
    logic       pay_fire;
    logic       push;
    logic       pop;
    logic [1:0] hdr_type;
    logic       hdr_is_data;
    logic       hdr_is_legal;

    assign fifo_full    = (count_q == FULL_CNT);
    assign fifo_empty   = (count_q == '0);
    assign last_beat    = (beat_cnt_q == LAST_BEAT);
    assign hdr_type     = link_in_data[1:0];
    assign hdr_is_data  = (hdr_type == HDR_DATA);
    assign hdr_is_legal = hdr_is_data || (hdr_type == HDR_STATUS);

    assign beat_fire    = link_in_valid && link_in_ready;
    assign hdr_fire     = beat_fire && (state_q == ST_HDR);
    assign pay_fire     = beat_fire && (state_q == ST_PAYLOAD);
    assign push         = pay_fire && last_beat;
    assign pop          = final_fifo_in_valid && final_fifo_in_ready;

    // Link back-pressure: only the last payload beat can stall, and only on
    // the registered full flag (a same-cycle pop does not open the gate).
    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // so no path through the block leaves it unassigned and infers a latch.
        link_in_ready = 1'b0;
        if (reset) begin
            if ((state_q == ST_PAYLOAD) && last_beat) begin
                link_in_ready = !fifo_full;
            end else begin
                link_in_ready = 1'b1;
            end
        end
    end

    // Merge the current beat into its LSB-first slot of the assembly word.
    always_comb begin
        asm_next = asm_q;
        for (int k = 0; k < BEATS; k++) begin
            if (beat_cnt_q == BEAT_W'(k)) begin
                asm_next[k*LINK_WIDTH +: LINK_WIDTH] = link_in_data;
            end
        end
    end

    // Bits of the final beat beyond FINAL_FIFO_WIDTH are discarded.
    generate
        if (ASM_W > FINAL_FIFO_WIDTH) begin : g_excess
            logic unused_excess_bits;
            assign unused_excess_bits = ^asm_next[ASM_W-1:FINAL_FIFO_WIDTH];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Frame FSM and beat counter
    // ------------------------------------------------------------------
    // HDR waits for a header; a data header opens a BEATS-long payload.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples pre-edge values regardless of statement order.
            state_q    <= ST_HDR;
            beat_cnt_q <= '0;
        end else if (hdr_fire) begin
            if (hdr_is_data) begin
                state_q    <= ST_PAYLOAD;
                beat_cnt_q <= '0;
            end
        end else if (pay_fire) begin
            if (last_beat) begin
                state_q    <= ST_HDR;
                beat_cnt_q <= '0;
            end else begin
                beat_cnt_q <= beat_cnt_q + BEAT_W'(1);
            end
        end
    end

    // Assembly register collects payload beats of the frame in progress.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            asm_q <= '0;
        end else if (hdr_fire && hdr_is_data) begin
            asm_q <= '0;
        end else if (pay_fire) begin
            asm_q <= asm_next;
        end
    end

    // Remote status flags are taken from every legal header; illegal ones only flag an error.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            has_message_flying_otherside <= 1'b0;
            has_odd_clusters_otherside   <= 1'b0;
            status_seen                  <= 1'b0;
            protocol_error               <= 1'b0;
        end else if (hdr_fire) begin
            if (hdr_is_legal) begin
                has_message_flying_otherside <= link_in_data[2];
                has_odd_clusters_otherside   <= link_in_data[3];
                status_seen                  <= 1'b1;
            end else begin
                protocol_error               <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Word FIFO
    // ------------------------------------------------------------------
    // Storage write on push of a completed word.
    always_ff @(posedge clk) begin
        // NOTE: the storage array has no reset; occupancy and pointers are
        // reset instead, and the output is masked while the FIFO is empty.
        if (push) begin
            mem[wr_ptr_q] <= asm_next[FINAL_FIFO_WIDTH-1:0];
        end
    end

    // Pointers wrap naturally modulo FIFO_DEPTH; count holds on push+pop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

    assign final_fifo_in_valid = !fifo_empty;
    assign final_fifo_in_data  = fifo_empty ? '0 : mem[rd_ptr_q];
    assign fifo_count          = count_q;

endmodule

// File: tb/tb_final_fifo_link_receiver.sv
// Directed testbench for final_fifo_link_receiver at default parameters
// (FINAL_FIFO_WIDTH = 25, BEATS = 4, LINK_WIDTH = 8, FIFO_DEPTH = 4).
// Inputs change on the falling edge or just after the rising edge; outputs
// are observed on the falling edge.

module tb_final_fifo_link_receiver;

    logic        clk;
    logic        reset;
    logic [7:0]  link_in_data;
    logic        link_in_valid;
    logic        link_in_ready;
    logic [24:0] final_fifo_in_data;
    logic        final_fifo_in_valid;
    logic        final_fifo_in_ready;
    logic        has_message_flying_otherside;
    logic        has_odd_clusters_otherside;
    logic        status_seen;
    logic        protocol_error;
    logic [2:0]  fifo_count;

    int n_checks = 0;
    int n_pass   = 0;
    logic rdy_first;

    final_fifo_link_receiver dut (
        .clk                          (clk),
        .reset                        (reset),
        .link_in_data                 (link_in_data),
        .link_in_valid                (link_in_valid),
        .link_in_ready                (link_in_ready),
        .final_fifo_in_data           (final_fifo_in_data),
        .final_fifo_in_valid          (final_fifo_in_valid),
        .final_fifo_in_ready          (final_fifo_in_ready),
        .has_message_flying_otherside (has_message_flying_otherside),
        .has_odd_clusters_otherside   (has_odd_clusters_otherside),
        .status_seen                  (status_seen),
        .protocol_error               (protocol_error),
        .fifo_count                   (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Present one beat and hold it until accepted (bounded wait).
    task automatic send_beat(input logic [7:0] d);
        int waited;
        waited = 0;
        @(negedge clk);
        link_in_data  = d;
        link_in_valid = 1'b1;
        rdy_first     = link_in_ready;
        while (!link_in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!link_in_ready) check("beat_timeout", {31'd0, link_in_ready}, 32'd1);
        @(posedge clk);
        #1;
        link_in_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] hdr, input logic [31:0] payload);
        send_beat(hdr);
        for (int k = 0; k < 4; k++) send_beat(payload[k*8 +: 8]);
    endtask

    // Check the head word, then pop it.
    task automatic pop_check(input string tag, input logic [24:0] exp);
        @(negedge clk);
        check({tag, "_valid"}, {31'd0, final_fifo_in_valid}, 32'd1);
        check({tag, "_data"}, {7'd0, final_fifo_in_data}, {7'd0, exp});
        final_fifo_in_ready = 1'b1;
        @(posedge clk);
        #1;
        final_fifo_in_ready = 1'b0;
    endtask

    logic [31:0] pay [5];
    logic [24:0] wexp [5];

    initial begin
        pay[0] = 32'h00015A11; wexp[0] = 25'h0015A11;
        pay[1] = 32'h00025A22; wexp[1] = 25'h0025A22;
        pay[2] = 32'h00035A33; wexp[2] = 25'h0035A33;
        pay[3] = 32'h00045A44; wexp[3] = 25'h0045A44;
        pay[4] = 32'h00055A55; wexp[4] = 25'h0055A55;

        reset               = 1'b0;
        link_in_data        = 8'h00;
        link_in_valid       = 1'b0;
        final_fifo_in_ready = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_ready",  {31'd0, link_in_ready}, 32'd0);
        check("rst_valid",  {31'd0, final_fifo_in_valid}, 32'd0);
        check("rst_data",   {7'd0, final_fifo_in_data}, 32'd0);
        check("rst_msg",    {31'd0, has_message_flying_otherside}, 32'd0);
        check("rst_odd",    {31'd0, has_odd_clusters_otherside}, 32'd0);
        check("rst_seen",   {31'd0, status_seen}, 32'd0);
        check("rst_perr",   {31'd0, protocol_error}, 32'd0);
        check("rst_count",  {29'd0, fifo_count}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rel_ready",  {31'd0, link_in_ready}, 32'd1);

        // Status-only header
        send_beat(8'h0E);
        @(negedge clk);
        check("st_msg",     {31'd0, has_message_flying_otherside}, 32'd1);
        check("st_odd",     {31'd0, has_odd_clusters_otherside}, 32'd1);
        check("st_seen",    {31'd0, status_seen}, 32'd1);
        check("st_count",   {29'd0, fifo_count}, 32'd0);
        check("st_valid",   {31'd0, final_fifo_in_valid}, 32'd0);

        // One data frame with consumer ready
        final_fifo_in_ready = 1'b1;
        send_frame(8'h05, 32'h01332211);
        @(negedge clk);
        check("d1_valid",   {31'd0, final_fifo_in_valid}, 32'd1);
        check("d1_data",    {7'd0, final_fifo_in_data}, 32'h01332211);
        check("d1_msg",     {31'd0, has_message_flying_otherside}, 32'd1);
        check("d1_odd",     {31'd0, has_odd_clusters_otherside}, 32'd0);
        @(negedge clk);
        check("d1_drained", {29'd0, fifo_count}, 32'd0);
        final_fifo_in_ready = 1'b0;

        // Five frames against a stalled consumer
        for (int i = 0; i < 4; i++) send_frame(8'h0D, pay[i]);
        @(negedge clk);
        check("f4_count",   {29'd0, fifo_count}, 32'd4);
        send_beat(8'h0D);
        check("f5_rdy_hdr", {31'd0, rdy_first}, 32'd1);
        for (int k = 0; k < 3; k++) begin
            send_beat(pay[4][k*8 +: 8]);
            check("f5_rdy_mid", {31'd0, rdy_first}, 32'd1);
        end
        @(negedge clk);
        link_in_data  = pay[4][31:24];
        link_in_valid = 1'b1;
        check("f5_rdy_last", {31'd0, link_in_ready}, 32'd0);
        check("f5_count",    {29'd0, fifo_count}, 32'd4);
        check("f5_head",     {7'd0, final_fifo_in_data}, {7'd0, wexp[0]});
        final_fifo_in_ready = 1'b1;
        @(posedge clk);
        #1;
        final_fifo_in_ready = 1'b0;
        @(negedge clk);
        check("f5_rdy_back", {31'd0, link_in_ready}, 32'd1);
        check("f5_count3",   {29'd0, fifo_count}, 32'd3);
        @(posedge clk);
        #1;
        link_in_valid = 1'b0;
        @(negedge clk);
        check("f5_count4",   {29'd0, fifo_count}, 32'd4);
        for (int i = 1; i < 5; i++) pop_check("f5_pop", wexp[i]);
        @(negedge clk);
        check("f5_empty",    {29'd0, fifo_count}, 32'd0);

        // Illegal header
        send_beat(8'h03);
        @(negedge clk);
        check("ill_perr",   {31'd0, protocol_error}, 32'd1);
        check("ill_msg",    {31'd0, has_message_flying_otherside}, 32'd1);
        check("ill_odd",    {31'd0, has_odd_clusters_otherside}, 32'd1);
        check("ill_count",  {29'd0, fifo_count}, 32'd0);
        send_frame(8'h05, 32'hFFABCDEF);
        @(negedge clk);
        check("ill_perr2",  {31'd0, protocol_error}, 32'd1);
        check("ill_msg2",   {31'd0, has_message_flying_otherside}, 32'd1);
        check("ill_odd2",   {31'd0, has_odd_clusters_otherside}, 32'd0);
        pop_check("ill_word", 25'h1ABCDEF);

        // Reset mid-frame with a buffered word
        send_frame(8'h09, 32'h00000077);
        @(negedge clk);
        check("mr_count1",  {29'd0, fifo_count}, 32'd1);
        check("mr_odd",     {31'd0, has_odd_clusters_otherside}, 32'd1);
        send_beat(8'h05);
        send_beat(8'hAA);
        send_beat(8'hBB);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("mr_count0",  {29'd0, fifo_count}, 32'd0);
        check("mr_valid",   {31'd0, final_fifo_in_valid}, 32'd0);
        check("mr_ready",   {31'd0, link_in_ready}, 32'd0);
        check("mr_perr",    {31'd0, protocol_error}, 32'd0);
        check("mr_seen",    {31'd0, status_seen}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        send_frame(8'h05, 32'h01234567);
        @(negedge clk);
        check("mr_fresh_cnt", {29'd0, fifo_count}, 32'd1);
        pop_check("mr_fresh", 25'h1234567);

        // Push and pop in the same cycle at occupancy 3
        send_frame(8'h05, 32'h000000A1);
        send_frame(8'h05, 32'h000000A2);
        send_frame(8'h05, 32'h000000A3);
        @(negedge clk);
        check("pp_count3",  {29'd0, fifo_count}, 32'd3);
        send_beat(8'h05);
        send_beat(8'hA4);
        send_beat(8'h00);
        send_beat(8'h00);
        @(negedge clk);
        link_in_data        = 8'h00;
        link_in_valid       = 1'b1;
        final_fifo_in_ready = 1'b1;
        check("pp_rdy",     {31'd0, link_in_ready}, 32'd1);
        @(posedge clk);
        #1;
        link_in_valid       = 1'b0;
        final_fifo_in_ready = 1'b0;
        @(negedge clk);
        check("pp_count",   {29'd0, fifo_count}, 32'd3);
        pop_check("pp_a2", 25'h00000A2);
        pop_check("pp_a3", 25'h00000A3);
        pop_check("pp_a4", 25'h00000A4);
        @(negedge clk);
        check("pp_empty",   {29'd0, fifo_count}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/final_fifo_link_receiver.md
Name: final_fifo_link_receiver

Overview:
- Receive end of the inter-half link that carries final-FIFO words and status from the remote half of the split decoder.
- Deserialises narrow link beats into FINAL_FIFO_WIDTH words and buffers them in a small FIFO.
- Presents buffered words on a valid/ready interface to the local final arbitration unit's final_fifo_in port.
- Decodes the remote status bits into has_message_flying_otherside / has_odd_clusters_otherside for the local stage controller.

Parameters:
- CODE_DISTANCE_X, 5, X code distance; used only for width derivation.
- CODE_DISTANCE_Z, 4, Z code distance; used only for width derivation.
- LINK_WIDTH, 8, link beat width; must be >= 4.
- FIFO_DEPTH, 4, reassembled-word buffer depth; power of two, >= 2.
- Derived localparams: MEASUREMENT_ROUNDS=max(X,Z); ADDRESS_WIDTH=3*clog2(MEASUREMENT_ROUNDS); MASTER_FIFO_WIDTH=2*ADDRESS_WIDTH+2; FIFO_COUNT=MEASUREMENT_ROUNDS*CODE_DISTANCE_Z; FINAL_FIFO_WIDTH=MASTER_FIFO_WIDTH+clog2(FIFO_COUNT) (25 at defaults); BEATS=ceil(FINAL_FIFO_WIDTH/LINK_WIDTH) (4 at defaults).

Ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low: all state clears while reset==0; release is synchronised externally.
- link_in_data  in  LINK_WIDTH  beat from the remote transmitter.
- link_in_valid  in  1  beat valid.
- link_in_ready  out  1  beat accepted when valid&&ready.
- final_fifo_in_data  out  FINAL_FIFO_WIDTH  head-of-FIFO word.
- final_fifo_in_valid  out  1  FIFO not empty.
- final_fifo_in_ready  in  1  consumer pop.
- has_message_flying_otherside  out  1  last reported remote flag.
- has_odd_clusters_otherside  out  1  last reported remote flag.
- status_seen  out  1  set after the first legal header; sticky.
- protocol_error  out  1  sticky illegal-header flag.
- fifo_count  out  clog2(FIFO_DEPTH)+1  current occupancy.

Behaviour:
- Reset values: link_in_ready=0 while in reset, then 1; final_fifo_in_valid=0; data=0; both otherside flags=0; status_seen=0; protocol_error=0; fifo_count=0; FSM=HDR; beat counter=0.
- Header beat fields: [1:0] type, [2] has_message_flying, [3] has_odd_clusters, upper bits ignored.
- Type 2'b01 is a data header; 2'b10 is a status-only frame; 2'b00 and 2'b11 are illegal.
- Every accepted legal header registers bits [3:2] into the otherside flags and sets status_seen. The flags are visible the cycle after acceptance.
- An illegal header sets protocol_error, leaves the flags unchanged, and stays in HDR (beat dropped).
- FSM HDR: link_in_ready=1. A data header moves to PAYLOAD with beat counter=0; a status header stays in HDR.
- FSM PAYLOAD: accepts BEATS beats, LSB-first; beat k fills bits [k*LINK_WIDTH +: LINK_WIDTH]. Excess bits of the final beat are discarded.
- Last payload beat (counter==BEATS-1): link_in_ready = !fifo_full. On acceptance the assembled word is pushed and FSM returns to HDR.
- Non-last beats: link_in_ready=1. No bypass of a full FIFO by a same-cycle pop; ready is based on the registered full flag.
- The pushed word appears on final_fifo_in_data with valid=1 the cycle after the last beat is accepted, if the FIFO was empty.
- Pop on final_fifo_in_valid&&final_fifo_in_ready.
- Simultaneous push and pop: fifo_count is unchanged and order is preserved (FIFO, pointers wrap modulo FIFO_DEPTH).
- No valid&&ready → no state change; the beat counter holds mid-frame indefinitely.
- Asserting reset mid-frame discards the partial word and all buffered words immediately (asynchronous).
- Frames never interleave: a status header seen inside PAYLOAD is treated as payload data.

Test Plan:
- Reset release, then status header 8'h0E → next cycle has_message_flying_otherside=1, has_odd_clusters_otherside=1, status_seen=1, no FIFO push, fifo_count=0.
- Data header 8'h05 then payload beats 8'h11,22,33,01 with ready held at 1 → cycle after last beat: final_fifo_in_valid=1, data=25'h1332211, message flag=1, odd-clusters flag=0.
- Five back-to-back data frames with final_fifo_in_ready=0 → fifo_count=4. During frame 5, link_in_ready drops to 0 only on its last payload beat. A single pop reasserts ready the next cycle; words pop in send order.
- Header 8'h03 → protocol_error=1 sticky, flags unchanged. A following legal data frame is still received correctly.
- Reset driven low after 2 of 4 payload beats, then a fresh frame → only the fresh word is output, fifo_count=1.
- With the FIFO at 3 entries, push and pop in the same cycle → fifo_count stays 3 and head order is correct.
